// File: rtl/rr_mux_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_pkg
// Shared definitions for the round-robin mux arbiter:
//   - NCH            : number of requesting channels
//   - SEL_W          : width of a channel index / mux select
//   - WIDTH_DEFAULT  : default data width of a channel word
//   - PTR_RESET      : pointer value after reset (last channel, so channel 0
//                      is the first one searched)
//   - state_t        : arbiter FSM encoding (IDLE / CAPT / HOLD)
//   - onehot()       : decode a channel index into a one-hot channel vector
// -----------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

   localparam int NCH           = 4;
   localparam int SEL_W         = $clog2(NCH);
   localparam int WIDTH_DEFAULT = 4;

   localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(NCH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no transfer in progress
      ST_CAPT = 2'd1,   // sel driven, downstream mux settling
      ST_HOLD = 2'd2    // captured word presented to the consumer
   } state_t;

   function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NCH-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting at channel (ptr+1) mod NCH and
// moving upward with wrap-around, returns the first channel whose request bit
// is set.
// Ports:
//   req   in  [NCH-1:0]   request vector, bit n = channel n pending
//   ptr   in  [SEL_W-1:0] last granted channel (search starts just above it)
//   grant out [SEL_W-1:0] selected channel (meaningful only when any=1)
//   any   out             at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
   import rr_mux_arbiter_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             any
);

   // rot[k] is the request of the channel k+1 positions above ptr, so a plain
   // lowest-index priority search over rot gives the round-robin order.
   logic [NCH-1:0] rot;
   logic           found;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
         logic [SEL_W-1:0] idx;
         // Sum truncates to SEL_W bits, which is the modulo-NCH wrap.
         assign idx     = ptr + SEL_W'(gi + 1);
         assign rot[gi] = req[idx];
      end
   endgenerate

   always_comb begin
      grant = ptr + SEL_W'(1);
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && rot[i]) begin
            grant = ptr + SEL_W'(i + 1);
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter that steers an external NCH-to-1 mux and captures the
// selected channel word into an output register with a valid/ready handshake.
// One transfer takes IDLE -> CAPT -> HOLD -> IDLE; the sel register is held
// through CAPT so the external mux has a full cycle to settle before capture.
// Ports:
//   clk        in              clock, all state on rising edge
//   rst        in              synchronous active-high reset
//   req        in  [NCH-1:0]   per-channel request
//   ack        out [NCH-1:0]   one-hot capture pulse (high during CAPT only)
//   sel        out [SEL_W-1:0] channel select to the external mux
//   mux_out    in  [WIDTH-1:0] data returned by the external mux for sel
//   out_data   out [WIDTH-1:0] captured channel word
//   out_valid  out             out_data holds a valid word
//   out_ready  in              consumer accepts out_data with out_valid
// -----------------------------------------------------------------------------
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   req,
   output logic [NCH-1:0]   ack,
   output logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] mux_out,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state_reg, state_next;
   logic [SEL_W-1:0] sel_reg, sel_next;
   logic [SEL_W-1:0] ptr_reg, ptr_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic             out_valid_reg, out_valid_next;

   logic [SEL_W-1:0] pick_grant;
   logic             pick_any;

   rr_pick u_rr_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .any   (pick_any)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: if (pick_any)  state_next = ST_CAPT;
         ST_CAPT:                state_next = ST_HOLD;
         ST_HOLD: if (out_ready) state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   // ack is the only combinational output: it decodes sel while the word is
   // being captured, so the requester sees it in the same cycle as capture.
   always_comb begin
      ack = '0;
      if (state_reg == ST_CAPT) begin
         ack = onehot(sel_reg);
      end
   end

   // ------------------------------------------------------ datapath next values
   always_comb begin
      sel_next       = sel_reg;
      ptr_next       = ptr_reg;
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      unique case (state_reg)
         ST_IDLE: begin
            // sel only moves on the IDLE->CAPT edge.
            if (pick_any) sel_next = pick_grant;
         end
         ST_CAPT: begin
            // Capture regardless of whether req[sel] is still high; the
            // requester holds its data until ack.
            out_data_next  = mux_out;
            out_valid_next = 1'b1;
            // Pointer advances only on an actual capture.
            ptr_next       = sel_reg;
         end
         ST_HOLD: begin
            if (out_ready) out_valid_next = 1'b0;
         end
         default: begin
            out_valid_next = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_reg       <= '0;
         ptr_reg       <= PTR_RESET;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         sel_reg       <= sel_next;
         ptr_reg       <= ptr_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign sel       = sel_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Directed bench for rr_mux_arbiter. The external 4-to-1 mux is modelled by
// chan_data[sel]. Each expected capture (channel, word) is queued when the
// request is driven and compared when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   ack;
   logic [1:0]   sel;
   logic [W-1:0] mux_out;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   logic [W-1:0] chan_data [4];

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_out = chan_data[sel];

   rr_mux_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .ack       (ack),
      .sel       (sel),
      .mux_out   (mux_out),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [1:0] s);
      exp_t e;
      e.sel  = s;
      e.data = chan_data[s];
      sb.push_back(e);
   endtask

   // Waits (bounded) for out_valid; n returns the number of cycles waited.
   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!out_valid && n < 8) begin
         tick();
         n++;
      end
      check({tag, " valid"}, out_valid, 1);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, out_data);
         return;
      end
      e = sb.pop_front();
      check({tag, " data"}, out_data, e.data);
      check({tag, " sel"}, sel, e.sel);
   endtask

   // Full single-word transfer with the consumer ready.
   task automatic transfer(input string tag, input logic [3:0] r, input logic [1:0] exp_sel);
      int n;
      push_exp(exp_sel);
      req       = r;
      out_ready = 1'b1;
      tick();
      check({tag, " grant"}, sel, exp_sel);
      check({tag, " ack"}, ack, 4'b0001 << exp_sel);
      req = '0;
      wait_valid(tag, n);
      check({tag, " lat"}, n, 1);
      pop_check(tag);
      tick();
      check({tag, " drain"}, out_valid, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) chan_data[i] = '0;
      tick();
      tick();
      rst = 1'b0;

      // ---- reset state
      check("rst sel", sel, 0);
      check("rst valid", out_valid, 0);
      check("rst data", out_data, 0);
      check("rst ack", ack, 0);

      // ---- single request on channel 2
      chan_data[2] = 4'hA;
      push_exp(2'd2);
      req = 4'b0100;
      tick();
      check("ch2 sel", sel, 2);
      check("ch2 ack", ack, 4'b0100);
      req = '0;
      tick();
      check("ch2 ack gone", ack, 0);
      check("ch2 valid", out_valid, 1);
      pop_check("ch2");
      out_ready = 1'b1;
      tick();
      check("ch2 drain", out_valid, 0);
      out_ready = 1'b0;

      // ---- all requesting, rotation 0,1,2,3,0 at 3 cycles per word
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) chan_data[i] = W'(i + 5);
      push_exp(2'd0);
      push_exp(2'd1);
      push_exp(2'd2);
      push_exp(2'd3);
      push_exp(2'd0);
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_valid("rot", n);
         check("rot lat", n, 2);
         pop_check("rot");
         if (k == 4) req = '0;
         tick();
      end
      check("rot drain", out_valid, 0);
      out_ready = 1'b0;

      // ---- hold with consumer stalled, new requests ignored
      chan_data[1] = 4'h3;
      push_exp(2'd1);
      req = 4'b0010;
      tick();
      check("hold ack", ack, 4'b0010);
      tick();
      pop_check("hold");
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold stall valid", out_valid, 1);
         check("hold stall data", out_data, 4'h3);
         check("hold stall ack", ack, 0);
      end
      req       = '0;
      out_ready = 1'b1;
      tick();
      check("hold release", out_valid, 0);
      out_ready = 1'b0;
      tick();
      check("idle ack", ack, 0);
      check("idle sel", sel, 1);

      // ---- wrap-around after channel 3
      transfer("ch3", 4'b1000, 2'd3);
      transfer("wrap", 4'b1001, 2'd0);

      // ---- reset during CAPT: no ack after reset edge
      req = 4'b0100;
      tick();
      check("capt rst pre ack", ack, 4'b0100);
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      check("capt rst ack", ack, 0);
      check("capt rst valid", out_valid, 0);
      check("capt rst sel", sel, 0);

      // ---- reset during HOLD with out_data = F
      chan_data[2] = 4'hF;
      push_exp(2'd2);
      req = 4'b0100;
      tick();
      req = '0;
      tick();
      pop_check("hold F");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hold rst valid", out_valid, 0);
      check("hold rst data", out_data, 0);
      check("hold rst sel", sel, 0);
      transfer("post rst", 4'b1010, 2'd1);

      // ---- lone requester drops req during CAPT
      chan_data[1] = 4'h7;
      push_exp(2'd1);
      req = 4'b0010;
      tick();
      check("drop ack", ack, 4'b0010);
      req = '0;
      tick();
      check("drop valid", out_valid, 1);
      pop_check("drop");
      out_ready = 1'b1;
      tick();
      check("drop drain", out_valid, 0);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("drop idle ack", ack, 0);
         check("drop idle valid", out_valid, 0);
      end

      // ---- lone requester granted again
      transfer("lone again", 4'b0010, 2'd1);

      check("sb empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data width of each channel and of the captured output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req  input  4  per-channel request; bit n = channel n has data pending.
REQ-005 SHALL have port: ack  output  4  one-hot, one-cycle pulse; channel n data has been captured.
REQ-006 SHALL have port: sel  output  2  channel select, driven to the downstream 4-to-1 mux.
REQ-007 SHALL have port: mux_out  input  WIDTH  data returned by that mux for the current sel.
REQ-008 SHALL have port: out_data  output  WIDTH  captured channel data.
REQ-009 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts out_data when high together with out_valid.

Function
REQ-011 SHALL implement three states:
- IDLE: no transfer in progress.
- CAPT: sel stable, mux settling.
- HOLD: word presented to the consumer.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE with sel unchanged.
REQ-013 In IDLE with req!=0, the block SHALL, on the next edge:
- load sel with the granted channel g = first set req bit searching upward from (ptr+1) mod 4, wrapping;
- enter CAPT.
REQ-014 In CAPT, the block SHALL, on the next edge:
- load out_data<=mux_out and set out_valid<=1;
- set ptr<=sel;
- enter HOLD.
REQ-015 ack SHALL equal the one-hot decode of sel while in CAPT and 0 in every other state (combinational from state/sel).
REQ-016 In HOLD, out_valid SHALL stay 1 and out_data SHALL stay constant until a cycle with out_ready==1.
- On that edge: out_valid<=0 and state<=IDLE.
REQ-017 sel SHALL stay constant from the IDLE->CAPT edge until the next IDLE->CAPT edge.
REQ-018 Latency:
- first req edge to out_valid high = 2 cycles;
- with out_ready held high, one word per 3 cycles maximum.
REQ-019 If req[g] drops during CAPT, the block SHALL still capture mux_out and pulse ack[g]; the requester contract is to hold data and req until ack.
REQ-020 Requests arriving in CAPT or HOLD SHALL be ignored until the return to IDLE; they are never lost while req remains high.
REQ-021 With all four req bits held high, grants SHALL rotate 0,1,2,3,0,... (no starvation).
REQ-022 ptr SHALL update only on a capture; a lone requester SHALL be granted repeatedly.

Reset
REQ-023 rst SHALL be sampled at the rising edge of clk only; rst has priority over all other inputs.
REQ-024 Reset values SHALL be:
- state=IDLE, sel=0, out_data=0, out_valid=0;
- ptr=3, so channel 0 is granted first;
- ack=0.
REQ-025 rst asserted in CAPT or HOLD SHALL abort the transfer:
- the pending word is discarded;
- no ack is issued after the reset edge.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding (IDLE/CAPT/HOLD);
- NCH=4;
- the sel width constant;
- the WIDTH default.
REQ-027 The round-robin search SHALL be a combinational sub-module rr_pick, with:
- inputs req[3:0], ptr[1:0];
- outputs grant[1:0], any.
REQ-028 All outputs except ack SHALL be registered; no latches; no combinational path from mux_out to any output.

Verification
REQ-029 Reset, then req=4'b0100 with mux_out=4'hA -> the bench SHALL observe:
- sel=2 one cycle later;
- ack=4'b0100 for one cycle;
- out_data=4'hA, out_valid=1 two cycles after req.
REQ-030 req=4'b1111 held, out_ready=1, mux_out = channel index+5 -> the bench SHALL observe:
- out_data sequence 5,6,7,8,5;
- sel sequence 0,1,2,3,0.
REQ-031 Capture of 4'h3, out_ready=0 for 5 cycles -> the bench SHALL observe:
- out_valid=1 and out_data=4'h3 stable throughout;
- no new ack;
- IDLE one cycle after out_ready=1.
REQ-032 After channel 3 is granted, req=4'b1001 -> the bench SHALL observe channel 0 granted next (wrap-around).
REQ-033 rst asserted in HOLD with out_data=4'hF -> the bench SHALL observe next cycle:
- out_valid=0, out_data=0, sel=0;
- first grant after reset goes to the lowest set req bit.
REQ-034 req[1] alone, dropped during CAPT -> the bench SHALL observe:
- ack=4'b0010 pulse still issued;
- word captured;
- block returns to IDLE and stays there with req=0.
